// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// funct codes, FSM states and engine operation kinds.
package hilo_pkg;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_kind_t;

endpackage

// File: rtl/muldiv_core.sv
// Iterative radix-2 engine on unsigned magnitudes: shift-add multiply and
// restoring divide. result is the value the registers hold after one more step.
module muldiv_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  op_kind_t           kind,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    op_kind_t         kind_q, kind_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] low_next;

    // acc is the product high half (multiply) or the partial remainder (divide)
    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, (low_q[0] ? opb_q : '0)};
        shifted  = {acc_q, low_q[WIDTH-1]};
        diff     = shifted - {1'b0, opb_q};
        ge       = (shifted >= {1'b0, opb_q});
        acc_next = acc_q;
        low_next = low_q;
        if (kind_q == OP_MUL) begin
            acc_next = sum[WIDTH:1];
            low_next = {sum[0], low_q[WIDTH-1:1]};
        end else begin
            acc_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            low_next = {low_q[WIDTH-2:0], ge};
        end
        result = {acc_next, low_next};
    end

    always_comb begin
        acc_d  = acc_q;
        low_d  = low_q;
        opb_d  = opb_q;
        kind_d = kind_q;
        if (load) begin
            acc_d  = '0;
            low_d  = a;
            opb_d  = b;
            kind_d = kind;
        end else if (step) begin
            acc_d = acc_next;
            low_d = low_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            low_q  <= '0;
            opb_q  <= '0;
            kind_q <= OP_MUL;
        end else begin
            acc_q  <= acc_d;
            low_q  <= low_d;
            opb_q  <= opb_d;
            kind_q <= kind_d;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: decodes mul/div/move functs, stalls the pipeline while the
// iterative engine runs. Optional macro HILO_DIV0_TRAP_EN traps divide-by-zero.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    op_kind_t         kind_q, kind_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;

    logic               is_mul, is_div, is_signed, trap, start;
    logic               stall_c, core_load, core_step;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
    logic [2*WIDTH-1:0] raw, fixed;

    always_comb begin
        is_mul    = (funct == FN_MULT) || (funct == FN_MULTU);
        is_div    = (funct == FN_DIV) || (funct == FN_DIVU);
        is_signed = (funct == FN_MULT) || (funct == FN_DIV);
        mag_a     = (is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        mag_b     = (is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
`ifdef HILO_DIV0_TRAP_EN
        trap      = is_div && (rt_data == '0);
`else
        trap      = 1'b0;
`endif
        start     = (is_mul || is_div) && !trap;
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (core_load),
        .step   (core_step),
        .kind   (is_div ? OP_DIV : OP_MUL),
        .a      (mag_a),
        .b      (mag_b),
        .result (raw)
    );

    // Quotient negates on differing signs; remainder follows the dividend
    always_comb begin
        quo = raw[WIDTH-1:0];
        rem = raw[2*WIDTH-1:WIDTH];
        if (kind_q == OP_MUL) begin
            fixed = (neg_a_q ^ neg_b_q) ? -raw : raw;
        end else begin
            fixed = {(neg_a_q ? -rem : rem), ((neg_a_q ^ neg_b_q) ? -quo : quo)};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        kind_d    = kind_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        stall_c   = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        if (start) begin
                            stall_c   = 1'b1;
                            core_load = 1'b1;
                            cnt_d     = CW'(WIDTH - 1);
                            kind_d    = is_div ? OP_DIV : OP_MUL;
                            neg_a_d   = is_signed && rs_data[WIDTH-1];
                            neg_b_d   = is_signed && rt_data[WIDTH-1];
                            state_d   = BUSY;
                        end else if (trap) begin
                            stall_c = 1'b1;
                            state_d = DONE;
                        end else if (funct == FN_MTHI) begin
                            hi_d = rs_data;
                        end else if (funct == FN_MTLO) begin
                            lo_d = rs_data;
                        end
                    end
                end
                BUSY: begin
                    stall_c   = 1'b1;
                    core_step = 1'b1;
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = fixed;
                        state_d      = DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            kind_q  <= OP_MUL;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            kind_q  <= kind_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
        end
    end

`ifdef HILO_DIV0_TRAP_EN
    logic div0_q, div0_d;

    always_comb begin
        div0_d = !flush && (state_q == IDLE) && op_valid && trap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div0_q <= 1'b0;
        end else begin
            div0_q <= div0_d;
        end
    end

    assign div0 = div0_q;
`else
    assign div0 = 1'b0;
`endif

    // Gating with rst_n keeps stall low while reset is held, even with an op presented
    assign stall   = stall_c && rst_n;
    assign busy    = (state_q == BUSY);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = (op_valid && funct == FN_MFHI) ? hi_q :
                     (op_valid && funct == FN_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized self-checking bench for hilo_muldiv_ctrl (WIDTH=32) against an
// arithmetic reference model; follows HILO_DIV0_TRAP_EN when it is defined.
module tb_hilo_muldiv_ctrl;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;
    logic        div0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .funct    (funct),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .rd_data  (rd_data),
        .div0     (div0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: {hi,lo} from plain signed/unsigned arithmetic on the operands
    function automatic logic [63:0] refResult(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] old);
        longint sa, sb, q, m;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = old;
        case (f)
            FN_MULT:  r = sa * sb;
            FN_MULTU: r = {32'h0, a} * {32'h0, b};
            FN_DIV: begin
                if (b == 32'h0) begin
                    r = {a, ((sa < 0) ? 32'h1 : 32'hFFFFFFFF)};
                end else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            FN_DIVU: begin
                if (b == 32'h0) r = {a, 32'hFFFFFFFF};
                else            r = {a % b, a / b};
            end
            default: r = old;
        endcase
`ifdef HILO_DIV0_TRAP_EN
        if ((f == FN_DIV || f == FN_DIVU) && b == 32'h0) r = old;
`endif
        return r;
    endfunction

    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        logic        trap;
        int          n;
        int          busy_n;
        int          exp_stall;
        exp  = refResult(f, a, b, {exp_hi, exp_lo});
        trap = 1'b0;
`ifdef HILO_DIV0_TRAP_EN
        trap = (f == FN_DIV || f == FN_DIVU) && b == 32'h0;
`endif
        exp_stall = trap ? 1 : 33;
        @(negedge clk);
        op_valid = 1'b1;
        funct    = f;
        rs_data  = a;
        rt_data  = b;
        #1;
        n      = 0;
        busy_n = 0;
        while (stall === 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
            if (busy === 1'b1) busy_n++;
        end
        checkOutput($sformatf("stall_cycles f=%h", f), 64'(n), 64'(exp_stall));
        checkOutput("busy_cycles", 64'(busy_n), trap ? 64'd0 : 64'd32);
        checkOutput($sformatf("hi f=%h a=%h b=%h", f, a, b), {32'h0, hi}, {32'h0, exp[63:32]});
        checkOutput($sformatf("lo f=%h a=%h b=%h", f, a, b), {32'h0, lo}, {32'h0, exp[31:0]});
        checkOutput("done_div0", {63'h0, div0}, {63'h0, trap});
        checkOutput("done_rd_data", {32'h0, rd_data}, 64'h0);
        op_valid = 1'b0;
        exp_hi   = exp[63:32];
        exp_lo   = exp[31:0];
        @(negedge clk);
        #1;
        checkOutput("after_done_div0", {63'h0, div0}, 64'h0);
    endtask

    task automatic readHiLo(input string tag);
        @(negedge clk);
        op_valid = 1'b1;
        funct    = FN_MFHI;
        #1;
        checkOutput({tag, "_mfhi"}, {32'h0, rd_data}, {32'h0, exp_hi});
        checkOutput({tag, "_mfhi_stall"}, {63'h0, stall}, 64'h0);
        funct = FN_MFLO;
        #1;
        checkOutput({tag, "_mflo"}, {32'h0, rd_data}, {32'h0, exp_lo});
        op_valid = 1'b0;
    endtask

    task automatic moveTo(input logic [5:0] f, input logic [31:0] v);
        @(negedge clk);
        op_valid = 1'b1;
        funct    = f;
        rs_data  = v;
        #1;
        checkOutput("mt_stall", {63'h0, stall}, 64'h0);
        if (f == FN_MTHI) exp_hi = v;
        else              exp_lo = v;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        funct    = 6'h0;
        rs_data  = 32'h0;
        rt_data  = 32'h0;
        flush    = 1'b0;
        #1;
        checkOutput("reset_stall", {63'h0, stall}, 64'h0);
        checkOutput("reset_busy", {63'h0, busy}, 64'h0);
        checkOutput("reset_hi", {32'h0, hi}, 64'h0);
        checkOutput("reset_lo", {32'h0, lo}, 64'h0);
        checkOutput("reset_div0", {63'h0, div0}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(FN_MULT, 32'd7, 32'hFFFFFFFD);
        applyStimulus(FN_DIVU, 32'd100, 32'd7);
        readHiLo("divu");
        applyStimulus(FN_DIV, 32'hFFFFFFF9, 32'd2);
        applyStimulus(FN_DIV, 32'h80000000, 32'hFFFFFFFF);
        applyStimulus(FN_DIVU, 32'h12345678, 32'h0);
        applyStimulus(FN_DIV, 32'hFFFFFF00, 32'h0);
        moveTo(FN_MTHI, 32'h1234);
        readHiLo("mthi");
        moveTo(FN_MTLO, 32'hCAFE);
        readHiLo("mtlo");

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       f = FN_MULT;
                1:       f = FN_MULTU;
                2:       f = FN_DIV;
                default: f = FN_DIVU;
            endcase
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = b >> $urandom_range(8, 28);
                default: ;
            endcase
            applyStimulus(f, a, b);
            if (i % 6 == 0) readHiLo("rand");
        end

        // Flush in the tenth BUSY cycle must leave HI/LO untouched
        @(negedge clk);
        op_valid = 1'b1;
        funct    = FN_MULTU;
        rs_data  = 32'hFFFFFFFF;
        rt_data  = 32'hFFFFFFFF;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        checkOutput("flush_busy", {63'h0, busy}, 64'h1);
        checkOutput("flush_stall", {63'h0, stall}, 64'h0);
        @(negedge clk);
        flush    = 1'b0;
        op_valid = 1'b0;
        #1;
        checkOutput("post_flush_busy", {63'h0, busy}, 64'h0);
        checkOutput("post_flush_stall", {63'h0, stall}, 64'h0);
        repeat (40) @(negedge clk);
        checkOutput("post_flush_hi", {32'h0, hi}, {32'h0, exp_hi});
        checkOutput("post_flush_lo", {32'h0, lo}, {32'h0, exp_lo});

        // Reset in the middle of an operation clears everything at once
        @(negedge clk);
        op_valid = 1'b1;
        funct    = FN_MULTU;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        checkOutput("midreset_stall", {63'h0, stall}, 64'h0);
        checkOutput("midreset_busy", {63'h0, busy}, 64'h0);
        checkOutput("midreset_hi", {32'h0, hi}, 64'h0);
        checkOutput("midreset_lo", {32'h0, lo}, 64'h0);
        checkOutput("midreset_rd_data", {32'h0, rd_data}, 64'h0);
        checkOutput("midreset_div0", {63'h0, div0}, 64'h0);
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
